microsequencer_ctrl: RTL

MICROSEQUENCER_CTRL -- requirements
Module: microsequencer_ctrl

---
 rtl/ucode_pkg.sv | 49 ++++
 rtl/microsequencer_ctrl_seq_next_addr.sv | 36 +++
 rtl/microsequencer_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/ucode_pkg.sv
// Shared micro-code definitions for the microsequencer: FSM states, branch codes
// and the micro-ROM contents (branch code plus control word per micro-address).
package ucode_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [2:0] BC_NEXT   = 3'd0;
    localparam logic [2:0] BC_DISP_A = 3'd1;
    localparam logic [2:0] BC_DISP_B = 3'd2;
    localparam logic [2:0] BC_JUMP   = 3'd3;
    localparam logic [2:0] BC_RET    = 3'd4;

    localparam logic [3:0] JUMP_TARGET = 4'd7;
    localparam logic [3:0] ILLEGAL_LO  = 4'd13;

    typedef struct packed {
        logic [2:0] bc;
        logic [7:0] ctrl;
    } urom_entry_t;

    function automatic urom_entry_t urom_lookup(input logic [3:0] addr);
        urom_entry_t e;
        case (addr)
            4'd0:    e = '{bc: BC_NEXT,   ctrl: 8'h81};
            4'd1:    e = '{bc: BC_NEXT,   ctrl: 8'h42};
            4'd2:    e = '{bc: BC_NEXT,   ctrl: 8'h24};
            4'd3:    e = '{bc: BC_DISP_A, ctrl: 8'h18};
            4'd4:    e = '{bc: BC_JUMP,   ctrl: 8'h11};
            4'd5:    e = '{bc: BC_JUMP,   ctrl: 8'h22};
            4'd6:    e = '{bc: BC_NEXT,   ctrl: 8'h33};
            4'd7:    e = '{bc: BC_NEXT,   ctrl: 8'h0F};
            4'd8:    e = '{bc: BC_NEXT,   ctrl: 8'hF0};
            4'd9:    e = '{bc: BC_NEXT,   ctrl: 8'h3C};
            4'd10:   e = '{bc: BC_DISP_B, ctrl: 8'hC3};
            4'd11:   e = '{bc: BC_RET,    ctrl: 8'h5A};
            4'd12:   e = '{bc: BC_RET,    ctrl: 8'hA5};
            default: e = '{bc: BC_RET,    ctrl: 8'h00};
        endcase
        return e;
    endfunction

    function automatic logic is_illegal(input logic [3:0] addr);
        return (addr >= ILLEGAL_LO);
    endfunction

endpackage

// File: rtl/microsequencer_ctrl_seq_next_addr.sv
// Combinational next micro-address selection from the current address,
// its branch code and the dispatch operand.
module seq_next_addr
    import ucode_pkg::*;
(
    input  logic [3:0] upc,
    input  logic [2:0] bc,
    input  logic [1:0] op_in,
    output logic [3:0] next_upc
);

    // Branch-code driven successor address; every return code goes back to 0.
    always_comb begin
        next_upc = 4'd0;
        case (bc)
            BC_NEXT:   next_upc = upc + 4'd1;
            BC_DISP_A: begin
                case (op_in)
                    2'd0:    next_upc = 4'd4;
                    2'd1:    next_upc = 4'd5;
                    default: next_upc = 4'd6;
                endcase
            end
            BC_DISP_B: begin
                if (op_in == 2'd0) begin
                    next_upc = 4'd11;
                end else begin
                    next_upc = 4'd12;
                end
            end
            BC_JUMP:   next_upc = JUMP_TARGET;
            default:   next_upc = 4'd0;
        endcase
    end

endmodule

// File: rtl/microsequencer_ctrl.sv
// Two-state microsequencer: steps a 16-entry micro-ROM, dispatches on op_in,
// and counts completed instructions.
module microsequencer_ctrl
    import ucode_pkg::*;
#(
    parameter int CW_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op_in,
    input  logic            op_valid,
    output logic            op_ack,
    input  logic            stall,
    output logic [3:0]      upc,
    output logic [2:0]      branch_ctl,
    output logic [CW_W-1:0] ctrl_word,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      instr_cnt
);

    state_e      state_q, state_d;
    logic [3:0]  upc_q, upc_d;
    logic [7:0]  cnt_q, cnt_d;

    urom_entry_t entry_s;
    logic [3:0]  next_upc_s;
    logic        run_s;
    logic        dispatch_s;
    logic        retire_s;
    logic        ret_s;

    assign entry_s = urom_lookup(upc_q);

    seq_next_addr u_next (
        .upc      (upc_q),
        .bc       (entry_s.bc),
        .op_in    (op_in),
        .next_upc (next_upc_s)
    );

    // Retire qualification, pulse outputs and next-state computation.
    always_comb begin
        run_s      = (state_q == ST_RUN);
        dispatch_s = (entry_s.bc == BC_DISP_A) || (entry_s.bc == BC_DISP_B);
        ret_s      = entry_s.bc[2];
        // stall wins over op_valid and start; dispatches also wait for an operand
        retire_s   = run_s && !stall && (!dispatch_s || op_valid);

        op_ack     = run_s && dispatch_s && op_valid && !stall;
        done       = retire_s && ret_s;
        err        = retire_s && is_illegal(upc_q);
        branch_ctl = entry_s.bc;
        if (run_s) begin
            ctrl_word = CW_W'(entry_s.ctrl);
        end else begin
            ctrl_word = {CW_W{1'b0}};
        end

        state_d = state_q;
        upc_d   = upc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                upc_d = 4'd0;
                if (start && !stall) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (retire_s && ret_s) begin
                    state_d = ST_IDLE;
                    upc_d   = 4'd0;
                    cnt_d   = cnt_q + 8'd1;
                end else if (retire_s) begin
                    upc_d = next_upc_s;
                end else begin
                    upc_d = upc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                upc_d   = 4'd0;
            end
        endcase
    end

    // State, micro-PC and instruction counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            upc_q   <= 4'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign upc       = upc_q;
    assign busy      = (state_q == ST_RUN);
    assign instr_cnt = cnt_q;

endmodule
